// File: rtl/cache_wt_ctrl.sv
// cache_wt_ctrl
// Controller for a direct-mapped, write-through, write-allocate cache of
// 4 lines x 4 words x 32 bits. It owns the tag/valid/data arrays and runs
// every CPU access against a multi-cycle main memory.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cpu_req/write/addr/wd CPU request, sampled only in IDLE
//   cpu_rd/ready/hit      completion: one-cycle cpu_ready pulse, read data and
//                         hit flag valid with it
//   mem_req/write/addr/wd memory request held until mem_ack; line read or
//                         word write
//   mem_rd, mem_ack       fetched line (word 0 in the top 32 bits) and the
//                         one-cycle completion
//   hit_cnt, miss_cnt     saturating access statistics
module cache_wt_ctrl #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wd,
    output logic [31:0]       cpu_rd,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [127:0]      mem_rd,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TAG_W = ADDR_W - 6;

    typedef enum logic [2:0] {IDLE, COMPARE, FETCH, WRITE_MEM, DONE} state_t;

    state_t            state;
    logic [3:0]        valid;
    logic [TAG_W-1:0]  tags [4];
    logic [31:0]       data [4][4];

    // Latched request; byte-offset bits are never needed.
    logic              req_write;
    logic [ADDR_W-3:0] req_waddr;
    logic [31:0]       req_wd;

    logic [1:0]        idx;
    logic [1:0]        word;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic              addr_lsb_unused;

    assign idx             = req_waddr[3:2];
    assign word            = req_waddr[1:0];
    assign tag             = req_waddr[ADDR_W-3:4];
    assign hit             = valid[idx] && (tags[idx] == tag);
    assign addr_lsb_unused = ^cpu_addr[1:0];

    // Word 0 of a line sits in the most significant 32 bits.
    function automatic logic [31:0] line_word(input logic [127:0] line,
                                              input logic [1:0]   w);
        return line[(3 - int'(w)) * 32 +: 32];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            req_write <= 1'b0;
            req_waddr <= '0;
            req_wd    <= '0;
            cpu_rd    <= '0;
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wd    <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_write <= cpu_write;
                        req_waddr <= cpu_addr[ADDR_W-1:2];
                        req_wd    <= cpu_wd;
                        state     <= COMPARE;
                    end
                end

                COMPARE: begin
                    cpu_hit <= hit;
                    if (hit) begin
                        if (hit_cnt != '1)
                            hit_cnt <= hit_cnt + CNT_W'(1);
                        if (req_write) begin
                            // Update the cached copy now; memory follows.
                            data[idx][word] <= req_wd;
                            mem_req   <= 1'b1;
                            mem_write <= 1'b1;
                            mem_addr  <= {req_waddr, 2'b00};
                            mem_wd    <= req_wd;
                            state     <= WRITE_MEM;
                        end else begin
                            cpu_rd <= data[idx][word];
                            state  <= DONE;
                        end
                    end else begin
                        if (miss_cnt != '1)
                            miss_cnt <= miss_cnt + CNT_W'(1);
                        mem_req   <= 1'b1;
                        mem_write <= 1'b0;
                        mem_addr  <= {req_waddr[ADDR_W-3:2], 4'b0000};
                        state     <= FETCH;
                    end
                end

                FETCH: begin
                    if (mem_ack) begin
                        valid[idx] <= 1'b1;
                        tags[idx]  <= tag;
                        // Allocate the line, merging the write word if any.
                        for (int w = 0; w < 4; w++) begin
                            if (req_write && (2'(w) == word))
                                data[idx][w] <= req_wd;
                            else
                                data[idx][w] <= line_word(mem_rd, 2'(w));
                        end
                        if (req_write) begin
                            // mem_req stays high: the word write follows
                            // directly as the next memory transaction.
                            mem_write <= 1'b1;
                            mem_addr  <= {req_waddr, 2'b00};
                            mem_wd    <= req_wd;
                            state     <= WRITE_MEM;
                        end else begin
                            cpu_rd  <= line_word(mem_rd, word);
                            mem_req <= 1'b0;
                            state   <= DONE;
                        end
                    end
                end

                WRITE_MEM: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
